// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register address width, hazard FSM states and
// forwarding stage indices.
package cpu_pkg;

  localparam int DEF_REG_AW = 5;

  typedef enum logic {
    RUN      = 1'b0,
    LD_STALL = 1'b1
  } hz_state_e;

  // Stage indices as seen on stg_regwrite/stg_rd for the classic 2-stage case.
  localparam int STG_MEM_WB = 0;
  localparam int STG_EX_MEM = 1;

endpackage

// File: rtl/fwd_prio_sel.sv
// Priority forwarding matcher for one source operand over NUM_STG stages;
// the youngest (highest index) matching stage wins.
module fwd_prio_sel
  import cpu_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_STG = 2
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_STG-1:0]        stg_regwrite,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd,
  output logic [NUM_STG-1:0]        sel
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = '0;
    // Ascending scan: a later (younger) match overwrites an older one.
    for (int k = 0; k < NUM_STG; k++) begin
      if (stg_regwrite[k] && (stg_rd[k*REG_AW +: REG_AW] != '0) &&
          (stg_rd[k*REG_AW +: REG_AW] == rs)) begin
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use stall FSM, memory-wait freeze and a saturating
// stall-cycle counter for the pipelined CPU.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [NUM_STG-1:0]          stg_regwrite,
  input  logic [NUM_STG*REG_AW-1:0]   stg_rd,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        ex_memread,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        mem_req,
  input  logic                        mem_ack,
  input  logic                        flush,
  output logic [NUM_SRC*NUM_STG-1:0]  fwd_sel,
  output logic                        stall_id,
  output logic                        freeze,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int                CNT_AW     = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_AW-1:0] CNT_RELOAD = CNT_AW'(LOAD_LAT - 1);
  localparam logic [CNT_AW-1:0] CNT_LAST   = CNT_AW'(1);

  hz_state_e                  state_q, state_d;
  logic [CNT_AW-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC*NUM_STG-1:0] fwd_raw;
  logic                       hazard;
  logic                       freeze_raw;
  logic                       stall_raw;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_prio_sel #(
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG)
    ) u_sel (
      .rs           (ex_rs[j*REG_AW +: REG_AW]),
      .stg_regwrite (stg_regwrite),
      .stg_rd       (stg_rd),
      .sel          (fwd_raw[j*NUM_STG +: NUM_STG])
    );
  end

  // A load into x0 never creates a dependency.
  always_comb begin
    hazard = 1'b0;
    if (ex_memread && (ex_rd != '0)) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (id_rs_used[j] && (id_rs[j*REG_AW +: REG_AW] == ex_rd)) hazard = 1'b1;
      end
    end
  end

  assign freeze_raw = mem_req & ~mem_ack;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      RUN: begin
        stall_raw = hazard;
        if (hazard && (LOAD_LAT > 1)) begin
          state_d = LD_STALL;
          cnt_d   = CNT_RELOAD;
        end
      end
      LD_STALL: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) state_d = RUN;
      end
    endcase
    // Memory wait suspends the bubble sequence; flush overrides everything.
    if (freeze_raw) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
    end
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall_raw || freeze_raw) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_id = stall_raw & ~rst;
  assign freeze   = freeze_raw & ~rst;
  assign fwd_sel  = rst ? '0 : fwd_raw;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: three instances (LOAD_LAT 1/3, 4-bit counter)
// sharing stimulus, checked against a bubble-count reference model.
module tb_hazard_fwd_unit;
  import cpu_pkg::*;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NG = 2;
  localparam int ND = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS*AW-1:0] ex_rs, id_rs;
  logic [NG-1:0]    stg_regwrite;
  logic [NG*AW-1:0] stg_rd;
  logic [NS-1:0]    id_rs_used;
  logic             ex_memread;
  logic [AW-1:0]    ex_rd;
  logic             mem_req, mem_ack, flush;

  logic [NS*NG-1:0] fwd_o   [ND];
  logic             stall_o [ND];
  logic             frz_o   [ND];
  logic [15:0]      cnt_a, cnt_b;
  logic [3:0]       cnt_c;
  logic [15:0]      cnt_o   [ND];

  int lat  [ND] = '{1, 3, 1};
  int cmax [ND] = '{65535, 65535, 15};
  int pend [ND];
  int scnt [ND];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .NUM_STG(NG), .LOAD_LAT(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_ack(mem_ack), .flush(flush),
    .fwd_sel(fwd_o[0]), .stall_id(stall_o[0]), .freeze(frz_o[0]), .stall_cnt(cnt_a));

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .NUM_STG(NG), .LOAD_LAT(3), .CNT_W(16)) dut_l3 (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_ack(mem_ack), .flush(flush),
    .fwd_sel(fwd_o[1]), .stall_id(stall_o[1]), .freeze(frz_o[1]), .stall_cnt(cnt_b));

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .NUM_STG(NG), .LOAD_LAT(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_ack(mem_ack), .flush(flush),
    .fwd_sel(fwd_o[2]), .stall_id(stall_o[2]), .freeze(frz_o[2]), .stall_cnt(cnt_c));

  assign cnt_o[0] = cnt_a;
  assign cnt_o[1] = cnt_b;
  assign cnt_o[2] = {12'b0, cnt_c};

  // ---------------- reference model ----------------
  function automatic logic [NS*NG-1:0] m_fwd();
    logic [NS*NG-1:0] r;
    logic             found;
    r = '0;
    if (rst) return r;
    for (int j = 0; j < NS; j++) begin
      found = 1'b0;
      for (int k = NG - 1; k >= 0; k--) begin
        if (!found && stg_regwrite[k] && stg_rd[k*AW +: AW] != 0 &&
            stg_rd[k*AW +: AW] == ex_rs[j*AW +: AW]) begin
          r[j*NG + k] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic m_hazard();
    logic h = 1'b0;
    for (int j = 0; j < NS; j++)
      if (ex_memread && ex_rd != 0 && id_rs_used[j] && id_rs[j*AW +: AW] == ex_rd) h = 1'b1;
    return h;
  endfunction

  function automatic logic m_freeze();
    return !rst && mem_req && !mem_ack;
  endfunction

  function automatic logic m_stall(int d);
    return !rst && !m_freeze() && (pend[d] > 0 || m_hazard());
  endfunction

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      pend[d] = 0;
      scnt[d] = 0;
    end
  endtask

  // Advance one clock edge and step the model with the inputs held across it.
  task automatic tick();
    logic s [ND];
    logic f, h;
    f = m_freeze();
    h = m_hazard();
    for (int d = 0; d < ND; d++) s[d] = m_stall(d);
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        pend[d] = 0;
        scnt[d] = 0;
      end else begin
        if ((s[d] || f) && scnt[d] < cmax[d]) scnt[d]++;
        if (flush) pend[d] = 0;
        else if (!f) begin
          if (pend[d] > 0) pend[d]--;
          else if (h) pend[d] = lat[d] - 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    ex_rs = '0; id_rs = '0; stg_regwrite = '0; stg_rd = '0; id_rs_used = '0;
    ex_memread = 1'b0; ex_rd = '0; mem_req = 1'b0; mem_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    clear_inputs();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_hazard(input logic on);
    ex_memread = on;
    ex_rd      = 5'd3;
    id_rs      = {5'd3, 5'd9};
    id_rs_used = 2'b10;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ex_rs = {5'd5, 5'd5}; stg_regwrite = 2'b11; stg_rd = {5'd5, 5'd5};
    set_hazard(1'b1);
    mem_req = 1'b1; mem_ack = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (stall_o[d] !== 1'b0 || frz_o[d] !== 1'b0 || fwd_o[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: stall=%b freeze=%b fwd=%b, expected all 0",
                 d, stall_o[d], frz_o[d], fwd_o[d]);
      end
      n_cmp++;
      if (cnt_o[d] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_cnt dut%0d: got %0d expected 0", d, cnt_o[d]);
      end
    end
    pulse_reset();
  endtask

  task automatic test_forwarding();
    logic [NS*NG-1:0] e;
    pulse_reset();
    ex_rs = {5'd0, 5'd5}; stg_regwrite = 2'b11; stg_rd = {5'd5, 5'd5};
    #1;
    n_cmp++;
    if (fwd_o[0][1:0] !== 2'(1 << STG_EX_MEM)) begin
      n_fail++; $display("FAIL fwd_both_stages: got %b expected 10", fwd_o[0][1:0]);
    end
    stg_regwrite = 2'b01;
    #1;
    n_cmp++;
    if (fwd_o[0][1:0] !== 2'(1 << STG_MEM_WB)) begin
      n_fail++; $display("FAIL fwd_mem_wb_only: got %b expected 01", fwd_o[0][1:0]);
    end
    stg_regwrite = 2'b11; stg_rd = '0; ex_rs = '0;
    #1;
    n_cmp++;
    if (fwd_o[0] !== 4'b0000) begin
      n_fail++; $display("FAIL fwd_x0: got %b expected 0000", fwd_o[0]);
    end
    ex_rs = {5'd7, 5'd2}; stg_regwrite = 2'b11; stg_rd = {5'd2, 5'd7};
    #1;
    n_cmp++;
    if (fwd_o[0] !== 4'b0110) begin
      n_fail++; $display("FAIL fwd_two_slots: got %b expected 0110", fwd_o[0]);
    end
    for (int i = 0; i < 60; i++) begin
      ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_regwrite = 2'($urandom);
      #1;
      e = m_fwd();
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (fwd_o[d] !== e) begin
          n_fail++;
          $display("FAIL fwd_random dut%0d rs=%h rd=%h we=%b: got %b expected %b",
                   d, ex_rs, stg_rd, stg_regwrite, fwd_o[d], e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_load_use_lat1();
    pulse_reset();
    set_hazard(1'b1);
    #1;
    n_cmp++;
    if (stall_o[0] !== 1'b1) begin n_fail++; $display("FAIL lat1_stall: got %b expected 1", stall_o[0]); end
    tick();
    set_hazard(1'b0);
    #1;
    n_cmp++;
    if (stall_o[0] !== 1'b0 || cnt_o[0] !== 16'd1) begin
      n_fail++; $display("FAIL lat1_release: stall=%b cnt=%0d expected 0/1", stall_o[0], cnt_o[0]);
    end
    pulse_reset();
    set_hazard(1'b1);
    id_rs_used = 2'b01;
    #1;
    n_cmp++;
    if (stall_o[0] !== 1'b0 || stall_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL unused_src_stall: got %b/%b expected 0/0", stall_o[0], stall_o[1]);
    end
    ex_rd = '0; id_rs = '0; id_rs_used = 2'b11;
    #1;
    n_cmp++;
    if (stall_o[0] !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b expected 0", stall_o[0]); end
    tick();
    n_cmp++;
    if (cnt_o[0] !== 16'd0) begin n_fail++; $display("FAIL no_stall_cnt: got %0d expected 0", cnt_o[0]); end
  endtask

  task automatic test_load_use_lat3();
    pulse_reset();
    set_hazard(1'b1);
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL lat3_first: got %b expected 1", stall_o[1]); end
    tick();
    set_hazard(1'b0);
    for (int c = 1; c < 3; c++) begin
      #1;
      n_cmp++;
      if (stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL lat3_cycle%0d: got %b expected 1", c, stall_o[1]); end
      tick();
    end
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0 || cnt_o[1] !== 16'd3 || cnt_o[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL lat3_done: stall=%b cnt3=%0d cnt1=%0d expected 0/3/1", stall_o[1], cnt_o[1], cnt_o[0]);
    end
  endtask

  task automatic test_freeze_mid_stall();
    pulse_reset();
    set_hazard(1'b1);
    tick();
    set_hazard(1'b0);
    tick();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (stall_o[1] !== 1'b0 || frz_o[1] !== 1'b1) begin
        n_fail++; $display("FAIL frz_mid_stall%0d: stall=%b freeze=%b expected 0/1", c, stall_o[1], frz_o[1]);
      end
      tick();
    end
    mem_req = 1'b0;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL frz_resume: got %b expected 1", stall_o[1]); end
    tick();
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0 || cnt_o[1] !== 16'd5) begin
      n_fail++; $display("FAIL frz_done: stall=%b cnt=%0d expected 0/5", stall_o[1], cnt_o[1]);
    end
    // Freeze and hazard together in RUN: freeze wins, hazard seen afterwards.
    pulse_reset();
    set_hazard(1'b1);
    mem_req = 1'b1; mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0 || frz_o[1] !== 1'b1) begin
      n_fail++; $display("FAIL frz_hazard: stall=%b freeze=%b expected 0/1", stall_o[1], frz_o[1]);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1 || frz_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL frz_redetect: stall=%b freeze=%b expected 1/0", stall_o[1], frz_o[1]);
    end
  endtask

  task automatic test_flush();
    pulse_reset();
    set_hazard(1'b1);
    tick();
    set_hazard(1'b0);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL flush_in_stall: got %b expected 1", stall_o[1]); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %b expected 0", stall_o[1]); end
    pulse_reset();
    set_hazard(1'b1);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL flush_hazard: got %b expected 1", stall_o[1]); end
    tick();
    set_hazard(1'b0);
    flush = 1'b0;
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_after: got %b expected 0", stall_o[1]); end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    set_hazard(1'b1);
    tick();
    set_hazard(1'b0);
    ex_rs = {5'd4, 5'd4}; stg_regwrite = 2'b11; stg_rd = {5'd4, 5'd4};
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b1 || cnt_o[1] !== 16'd1) begin
      n_fail++; $display("FAIL arst_pre: stall=%b cnt=%0d expected 1/1", stall_o[1], cnt_o[1]);
    end
    #1;
    rst = 1'b1;
    mem_req = 1'b1; mem_ack = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (stall_o[d] !== 1'b0 || frz_o[d] !== 1'b0 || fwd_o[d] !== '0 || cnt_o[d] !== 16'd0) begin
        n_fail++;
        $display("FAIL arst_mid dut%0d: stall=%b freeze=%b fwd=%b cnt=%0d expected all 0",
                 d, stall_o[d], frz_o[d], fwd_o[d], cnt_o[d]);
      end
    end
    model_clear();
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_o[1] !== 1'b0) begin n_fail++; $display("FAIL arst_back_in_run: got %b expected 0", stall_o[1]); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    mem_req = 1'b1; mem_ack = 1'b0;
    repeat (20) tick();
    mem_req = 1'b0;
    #1;
    n_cmp++;
    if (cnt_o[2] !== 16'd15 || cnt_o[0] !== 16'd20) begin
      n_fail++; $display("FAIL saturation: cnt4=%0d cnt16=%0d expected 15/20", cnt_o[2], cnt_o[0]);
    end
  endtask

  task automatic test_random();
    logic [NS*NG-1:0] ef;
    pulse_reset();
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ack      = 1'($urandom);
      ex_memread   = 1'($urandom);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used   = 2'($urandom);
      ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_regwrite = 2'($urandom);
      if (rst) model_clear();
      #1;
      ef = m_fwd();
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (stall_o[d] !== m_stall(d) || frz_o[d] !== m_freeze() || fwd_o[d] !== ef ||
            cnt_o[d] !== 16'(scnt[d])) begin
          n_fail++;
          $display("FAIL random dut%0d it=%0d: stall=%b/%b freeze=%b/%b fwd=%b/%b cnt=%0d/%0d (got/expected)",
                   d, i, stall_o[d], m_stall(d), frz_o[d], m_freeze(), fwd_o[d], ef, cnt_o[d], scnt[d]);
        end
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_clear();
    #1;
    test_reset();
    test_forwarding();
    test_load_use_lat1();
    test_load_use_lat3();
    test_freeze_mid_stall();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
